// File: rtl/cordic_ctrl.sv
// cordic_ctrl - sequencing controller for an iterative CORDIC datapath.
//
// Accepts one operation at a time through a valid/ready handshake. It steers
// the datapath input mux and shift counter through the load, iterate and
// hold phases, then presents the result until the consumer takes it.
//
// Optional feature: define CORDIC_CTRL_ABORT_EN to add the abort input and
// the aborted output. With the macro undefined, neither port exists.
//
// Ports
//   clk           in   1  single clock, rising edge
//   reset_n       in   1  asynchronous active-low reset
//   start_valid   in   1  requester offers an operation
//   start_ready   out  1  operation accepted (IDLE only)
//   mode_in       in   1  0 = rotation, 1 = vectoring; sampled on acceptance
//   result_valid  out  1  datapath holds a finished result
//   result_ready  in   1  consumer takes the result
//   cordic_mode   out  1  latched mode for the datapath
//   in_mux_ctl    out  2  00 rot load, 10 vec load, 01 feedback, 11 hold
//   counter_rst   out  1  clears the datapath shift counter
//   counter_hold  out  1  freezes the datapath shift counter
//   iter_cnt      out  4  current micro-rotation index
//   abort         in   1  (CORDIC_CTRL_ABORT_EN) cancel the running operation
//   aborted       out  1  (CORDIC_CTRL_ABORT_EN) one-cycle cancel indication
//
// state | meaning
// IDLE  | waiting for start_valid; datapath held
// LOAD  | one cycle loading operands, shift counter cleared
// ITER  | NUM_ITER feedback cycles, iter_cnt counts 0..NUM_ITER-1
// DONE  | result presented until result_ready
module cordic_ctrl #(
  parameter int unsigned NUM_ITER = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       mode_in,
  output logic       result_valid,
  input  logic       result_ready,
  output logic       cordic_mode,
  output logic [1:0] in_mux_ctl,
  output logic       counter_rst,
  output logic       counter_hold,
  output logic [3:0] iter_cnt
`ifdef CORDIC_CTRL_ABORT_EN
  ,
  input  logic       abort,
  output logic       aborted
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ITER = 4'(NUM_ITER - 1);
  localparam logic [1:0] MUX_FEED  = 2'b01;
  localparam logic [1:0] MUX_HOLD  = 2'b11;

  state_t     r_state;
  logic       r_start_ready;
  logic       r_result_valid;
  logic       r_cordic_mode;
  logic [1:0] r_in_mux_ctl;
  logic       r_counter_rst;
  logic       r_counter_hold;
  logic [3:0] r_iter_cnt;
  logic       w_abort;

`ifdef CORDIC_CTRL_ABORT_EN
  logic r_aborted;
  assign w_abort = abort;
  assign aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_start_ready  <= 1'b1;
      r_result_valid <= 1'b0;
      r_cordic_mode  <= 1'b0;
      r_in_mux_ctl   <= MUX_HOLD;
      r_counter_rst  <= 1'b0;
      r_counter_hold <= 1'b1;
      r_iter_cnt     <= 4'd0;
`ifdef CORDIC_CTRL_ABORT_EN
      r_aborted      <= 1'b0;
`endif
    end else begin
`ifdef CORDIC_CTRL_ABORT_EN
      r_aborted <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_state        <= S_LOAD;
            r_start_ready  <= 1'b0;
            r_cordic_mode  <= mode_in;
            // load select follows the mode being latched this same edge
            r_in_mux_ctl   <= {mode_in, 1'b0};
            r_counter_rst  <= 1'b1;
            r_counter_hold <= 1'b0;
            r_iter_cnt     <= 4'd0;
          end
        end
        S_LOAD, S_ITER: begin
          if (w_abort) begin
            r_state        <= S_IDLE;
            r_start_ready  <= 1'b1;
            r_in_mux_ctl   <= MUX_HOLD;
            r_counter_rst  <= 1'b0;
            r_counter_hold <= 1'b1;
`ifdef CORDIC_CTRL_ABORT_EN
            r_aborted      <= 1'b1;
`endif
          end else if (r_state == S_LOAD) begin
            r_state       <= S_ITER;
            r_in_mux_ctl  <= MUX_FEED;
            r_counter_rst <= 1'b0;
          end else if (r_iter_cnt == LAST_ITER) begin
            // index stays at the last value; cleared again on the next load
            r_state        <= S_DONE;
            r_result_valid <= 1'b1;
            r_in_mux_ctl   <= MUX_HOLD;
            r_counter_hold <= 1'b1;
          end else begin
            r_iter_cnt <= r_iter_cnt + 4'd1;
          end
        end
        S_DONE: begin
          if (result_ready) begin
            r_state        <= S_IDLE;
            r_result_valid <= 1'b0;
            r_start_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_ready  = r_start_ready;
  assign result_valid = r_result_valid;
  assign cordic_mode  = r_cordic_mode;
  assign in_mux_ctl   = r_in_mux_ctl;
  assign counter_rst  = r_counter_rst;
  assign counter_hold = r_counter_hold;
  assign iter_cnt     = r_iter_cnt;

endmodule

// File: tb/tb_cordic_ctrl.sv
// Directed bench for cordic_ctrl: main instance at NUM_ITER=8 plus two
// instances at NUM_ITER=1 and NUM_ITER=15 for the latency extremes.
module tb_cordic_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_valid, mode_in, result_ready;
  logic       start_ready, result_valid, cordic_mode;
  logic [1:0] in_mux_ctl;
  logic       counter_rst, counter_hold;
  logic [3:0] iter_cnt;

  logic       sv_1, rr_1, srdy_1, rv_1, cm_1, crst_1, chold_1;
  logic [1:0] mux_1;
  logic [3:0] cnt_1;
  logic       sv_15, rr_15, srdy_15, rv_15, cm_15, crst_15, chold_15;
  logic [1:0] mux_15;
  logic [3:0] cnt_15;

`ifdef CORDIC_CTRL_ABORT_EN
  logic abort, aborted;
  logic ab_1, abd_1, ab_15, abd_15;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cordic_ctrl #(.NUM_ITER(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .start_valid(start_valid),
    .start_ready(start_ready), .mode_in(mode_in), .result_valid(result_valid),
    .result_ready(result_ready), .cordic_mode(cordic_mode),
    .in_mux_ctl(in_mux_ctl), .counter_rst(counter_rst),
    .counter_hold(counter_hold), .iter_cnt(iter_cnt)
`ifdef CORDIC_CTRL_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  cordic_ctrl #(.NUM_ITER(1)) u_dut_1 (
    .clk(clk), .reset_n(reset_n), .start_valid(sv_1),
    .start_ready(srdy_1), .mode_in(mode_in), .result_valid(rv_1),
    .result_ready(rr_1), .cordic_mode(cm_1),
    .in_mux_ctl(mux_1), .counter_rst(crst_1),
    .counter_hold(chold_1), .iter_cnt(cnt_1)
`ifdef CORDIC_CTRL_ABORT_EN
    , .abort(ab_1), .aborted(abd_1)
`endif
  );

  cordic_ctrl #(.NUM_ITER(15)) u_dut_15 (
    .clk(clk), .reset_n(reset_n), .start_valid(sv_15),
    .start_ready(srdy_15), .mode_in(mode_in), .result_valid(rv_15),
    .result_ready(rr_15), .cordic_mode(cm_15),
    .in_mux_ctl(mux_15), .counter_rst(crst_15),
    .counter_hold(chold_15), .iter_cnt(cnt_15)
`ifdef CORDIC_CTRL_ABORT_EN
    , .abort(ab_15), .aborted(abd_15)
`endif
  );

  task automatic chk_val(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk_val({tag, ".start_ready"}, 32'(start_ready), 1);
    chk_val({tag, ".result_valid"}, 32'(result_valid), 0);
    chk_val({tag, ".in_mux_ctl"}, 32'(in_mux_ctl), 3);
    chk_val({tag, ".counter_rst"}, 32'(counter_rst), 0);
    chk_val({tag, ".counter_hold"}, 32'(counter_hold), 1);
  endtask

  initial begin
    reset_n = 1'b0; start_valid = 1'b0; mode_in = 1'b0; result_ready = 1'b0;
    sv_1 = 1'b0; rr_1 = 1'b0; sv_15 = 1'b0; rr_15 = 1'b0;
`ifdef CORDIC_CTRL_ABORT_EN
    abort = 1'b0; ab_1 = 1'b0; ab_15 = 1'b0;
`endif
    tick(); tick();

    // reset values
    chk_idle("rst");
    chk_val("rst.cordic_mode", 32'(cordic_mode), 0);
    chk_val("rst.iter_cnt", 32'(iter_cnt), 0);

    // start offered as reset releases: taken on the first edge (cycle 0)
    reset_n = 1'b1; start_valid = 1'b1; mode_in = 1'b0;
    tick();
    start_valid = 1'b0;
    chk_val("rot.load.mux", 32'(in_mux_ctl), 0);
    chk_val("rot.load.crst", 32'(counter_rst), 1);
    chk_val("rot.load.chold", 32'(counter_hold), 0);
    chk_val("rot.load.srdy", 32'(start_ready), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_val("rot.iter.mux", 32'(in_mux_ctl), 1);
      chk_val("rot.iter.cnt", 32'(iter_cnt), 32'(i));
      chk_val("rot.iter.crst", 32'(counter_rst), 0);
      chk_val("rot.iter.rv", 32'(result_valid), 0);
    end
    tick();  // cycle 10
    chk_val("rot.done.rv", 32'(result_valid), 1);
    chk_val("rot.done.mux", 32'(in_mux_ctl), 3);
    chk_val("rot.done.chold", 32'(counter_hold), 1);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk_idle("rot.idle");

    // vectoring, mode_in toggled while iterating
    start_valid = 1'b1; mode_in = 1'b1;
    tick();
    start_valid = 1'b0;
    chk_val("vec.load.mux", 32'(in_mux_ctl), 2);
    chk_val("vec.load.mode", 32'(cordic_mode), 1);
    for (int i = 0; i < 8; i++) begin
      mode_in = ~mode_in;
      tick();
      chk_val("vec.iter.mode", 32'(cordic_mode), 1);
    end
    tick();
    chk_val("vec.done.rv", 32'(result_valid), 1);
    chk_val("vec.done.mode", 32'(cordic_mode), 1);

    // consumer stalls 5 cycles while a new start is offered
    start_valid = 1'b1; mode_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_val("stall.rv", 32'(result_valid), 1);
      chk_val("stall.srdy", 32'(start_ready), 0);
      chk_val("stall.mode", 32'(cordic_mode), 1);
      chk_val("stall.mux", 32'(in_mux_ctl), 3);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk_idle("release");
    tick();  // start still offered: accepted only now
    start_valid = 1'b0;
    chk_val("restart.mux", 32'(in_mux_ctl), 0);
    chk_val("restart.mode", 32'(cordic_mode), 0);
    chk_val("restart.srdy", 32'(start_ready), 0);

    // reset pulsed mid-operation at iter_cnt=3
    for (int i = 0; i < 4; i++) tick();
    chk_val("mid.cnt", 32'(iter_cnt), 3);
    #2 reset_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk_val("async_rst.mode", 32'(cordic_mode), 0);
    chk_val("async_rst.cnt", 32'(iter_cnt), 0);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_val("post_rst.rv", 32'(result_valid), 0);
    end
    chk_idle("post_rst");

    // latency extremes: NUM_ITER=1 -> +3, NUM_ITER=15 -> +17
    sv_1 = 1'b1; sv_15 = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      sv_1 = 1'b0; sv_15 = 1'b0;
      chk_val("lat1.rv", 32'(rv_1), (k >= 3) ? 1 : 0);
      chk_val("lat15.rv", 32'(rv_15), (k >= 17) ? 1 : 0);
    end
    chk_val("lat15.cnt", 32'(cnt_15), 14);

`ifdef CORDIC_CTRL_ABORT_EN
    // abort at iter_cnt=4, then a normal operation
    start_valid = 1'b1; mode_in = 1'b0;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_val("abort.cnt", 32'(iter_cnt), 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_val("abort.pulse", 32'(aborted), 1);
    chk_idle("abort.idle");
    tick();
    chk_val("abort.pulse_end", 32'(aborted), 0);
    chk_val("abort.no_rv", 32'(result_valid), 0);
    start_valid = 1'b1; abort = 1'b1;
    tick();
    start_valid = 1'b0; abort = 1'b0;
    chk_val("abort.restart.mux", 32'(in_mux_ctl), 0);
    chk_val("abort.restart.srdy", 32'(start_ready), 0);
    for (int i = 0; i < 8; i++) tick();
    chk_val("abort.restart.pre", 32'(result_valid), 0);
    tick();
    chk_val("abort.restart.rv", 32'(result_valid), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_ctrl.md
CORDIC_CTRL -- requirements
Module: cordic_ctrl

Interface
REQ-001 SHALL have parameter NUM_ITER, default 8, giving micro-rotations per operation; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_valid  input  1  requester offers an operation.
REQ-005 SHALL have port start_ready  output  1  controller accepts an operation; high only in IDLE.
REQ-006 SHALL have port mode_in  input  1  requested mode, 0 = rotation, 1 = vectoring; sampled on acceptance.
REQ-007 SHALL have port result_valid  output  1  datapath outputs hold a finished result.
REQ-008 SHALL have port result_ready  input  1  consumer takes the result.
REQ-009 SHALL have port cordic_mode  output  1  latched mode driven to the datapath.
REQ-010 SHALL have port in_mux_ctl  output  2  datapath load select: 00 rotation load, 10 vectoring load, 01 feedback, 11 hold.
REQ-011 SHALL have port counter_rst  output  1  clears the datapath shift counter.
REQ-012 SHALL have port counter_hold  output  1  freezes the datapath shift counter.
REQ-013 SHALL have port iter_cnt  output  4  current micro-rotation index.

Function
REQ-014 SHALL implement states IDLE, LOAD, ITER, DONE, one-hot or binary.
REQ-015 SHALL, in IDLE with start_valid=1, complete the handshake, latch mode_in into cordic_mode and enter LOAD next cycle.
REQ-016 SHALL, in LOAD, drive in_mux_ctl = 10 if cordic_mode=1 else 00, counter_rst=1, counter_hold=0, for exactly one cycle, then enter ITER with iter_cnt=0.
REQ-017 SHALL, in ITER, drive in_mux_ctl=01, counter_rst=0, counter_hold=0, and increment iter_cnt each cycle.
REQ-018 SHALL leave ITER for DONE in the cycle after iter_cnt = NUM_ITER-1; ITER lasts exactly NUM_ITER cycles.
REQ-019 SHALL, in DONE, assert result_valid and drive in_mux_ctl=11, counter_hold=1, until result_ready=1, then enter IDLE next cycle.
REQ-020 SHALL, in IDLE, drive in_mux_ctl=11, counter_hold=1, counter_rst=0, result_valid=0.
REQ-021 SHALL give latency start acceptance to result_valid of exactly NUM_ITER+2 cycles.
REQ-022 SHALL hold cordic_mode constant from acceptance until the next acceptance; mode_in changes mid-operation ignored.
REQ-023 SHALL ignore start_valid outside IDLE; start_valid and result_ready high together in DONE -> IDLE only, new start accepted no earlier than the following cycle.
REQ-024 SHALL saturate never: iter_cnt returns to 0 on every LOAD, no wrap beyond NUM_ITER-1.

Reset
REQ-025 SHALL, on reset_n low, asynchronously enter IDLE with start_ready=1, result_valid=0, cordic_mode=0, in_mux_ctl=11, counter_rst=0, counter_hold=1, iter_cnt=0.
REQ-026 SHALL discard any operation in progress on reset; no result_valid produced for it.
REQ-027 SHALL leave reset synchronously on the first rising clk edge after reset_n rises, accepting start_valid on that edge.

Configuration
REQ-028 SHALL, with macro CORDIC_CTRL_ABORT_EN defined, add ports abort input 1 and aborted output 1.
REQ-029 SHALL, with CORDIC_CTRL_ABORT_EN, on abort=1 in LOAD or ITER, enter IDLE next cycle, pulse aborted for one cycle, not assert result_valid.
REQ-030 SHALL, with CORDIC_CTRL_ABORT_EN, ignore abort in IDLE and DONE; abort with start_valid in IDLE accepts the start.
REQ-031 SHALL, without CORDIC_CTRL_ABORT_EN, have neither port, and behave as REQ-014..REQ-024 only.

Verification
REQ-032 SHALL cover: reset, start_valid=1 mode_in=0 at cycle 0 -> LOAD in_mux_ctl=00 cycle 1, ITER cycles 2..9 iter_cnt 0..7, result_valid cycle 10.
REQ-033 SHALL cover: mode_in=1 accepted, mode_in toggled during ITER -> in_mux_ctl=10 in LOAD, cordic_mode stays 1 through DONE.
REQ-034 SHALL cover: result_ready held 0 for 5 cycles in DONE -> result_valid stays 1, start_ready 0, start_valid ignored; release -> IDLE next cycle.
REQ-035 SHALL cover: reset_n pulsed low at iter_cnt=3 -> immediate IDLE outputs per REQ-025, no result_valid afterwards.
REQ-036 SHALL cover: NUM_ITER=1 and NUM_ITER=15 -> result_valid at acceptance+3 and acceptance+17.
REQ-037 SHALL cover, with CORDIC_CTRL_ABORT_EN: abort at iter_cnt=4 -> aborted pulse one cycle, IDLE next cycle, new start accepted normally.
